// File: rtl/sha_ctrl_if.sv
// Bus-side command interface of sha_ctrl_core: message word in, digest word out,
// command write port and status/error read-back.
interface sha_ctrl_if #(
  parameter int DW = 32
);
  logic [DW-1:0] text_i;
  logic [DW-1:0] text_o;
  logic [2:0]    cmd_i;
  logic          cmd_w_i;
  logic [3:0]    cmd_o;
  logic          err_o;

  modport master (
    output text_i, cmd_i, cmd_w_i,
    input  text_o, cmd_o, err_o
  );

  modport slave (
    input  text_i, cmd_i, cmd_w_i,
    output text_o, cmd_o, err_o
  );
endinterface

// File: rtl/sha_ctrl_core.sv
// Control/datapath shell for the SHA core family: command register, message load,
// round sequencer, digest accumulate and read-out. Optional SHA_CMD_ERR_EN adds a sticky error flag.
module sha_ctrl_core #(
  parameter int DW           = 32,
  parameter int BLOCK_WORDS  = 16,
  parameter int DIGEST_WORDS = 8,
  parameter int ROUNDS       = 64
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  sha_ctrl_if.slave bus
);

  localparam int RNW = $clog2(ROUNDS + 1);
  localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int RCW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;

  localparam logic [WCW-1:0] WC_LAST  = WCW'(BLOCK_WORDS - 1);
  localparam logic [RNW-1:0] RND_LAST = RNW'(ROUNDS);
  localparam logic [RCW-1:0] RD_LAST  = RCW'(DIGEST_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cmd_q;
  logic [WCW-1:0]  wr_cnt_q;
  logic [RNW-1:0]  round_q;
  logic [RCW-1:0]  rd_cnt_q;
  logic [RCW-1:0]  rd_idx;
  logic            rd_active_q;
  logic            busy;
  logic [DW-1:0]   w_mem    [BLOCK_WORDS];
  logic [DW-1:0]   digest_q [DIGEST_WORDS];

  assign busy = (state_q != S_IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_q[1])              state_d = S_LOAD;
      S_LOAD:  if (wr_cnt_q == WC_LAST)   state_d = S_ROUND;
      S_ROUND: if (round_q == RND_LAST)   state_d = S_DONE;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // NOTE: state is assigned with <= so every flop samples pre-edge values,
  // regardless of statement order inside the block.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      wr_cnt_q    <= '0;
      round_q     <= '0;
      rd_cnt_q    <= '0;
      rd_active_q <= 1'b0;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q[3] <= busy;
      // A bus write beats the idle auto-clear of the Round/R request bits.
      if (bus.cmd_w_i)  cmd_q[2:0] <= bus.cmd_i;
      else if (!busy)   cmd_q[1:0] <= 2'b00;

      unique case (state_q)
        S_IDLE:  if (cmd_q[1]) wr_cnt_q <= '0;
        S_LOAD:  begin
          if (wr_cnt_q == WC_LAST) round_q  <= RNW'(1);
          else                     wr_cnt_q <= wr_cnt_q + 1'b1;
        end
        S_ROUND: if (round_q != RND_LAST) round_q <= round_q + 1'b1;
        S_DONE:  begin
          // cmd[2] selects chaining onto the previous digest versus a zero IV.
          for (int i = 0; i < DIGEST_WORDS; i++)
            digest_q[i] <= (cmd_q[2] ? digest_q[i] : '0) + w_mem[i % BLOCK_WORDS];
        end
        default: ;
      endcase

      // A fresh read request restarts the sequence even mid read-out.
      if (!busy && cmd_q[0]) begin
        rd_cnt_q    <= RD_LAST;
        rd_active_q <= 1'b1;
      end else if (rd_active_q) begin
        if (rd_cnt_q == '0) rd_active_q <= 1'b0;
        else                rd_cnt_q    <= rd_cnt_q - 1'b1;
      end
    end
  end

  // NOTE: the message store has no reset; every word is written in LOAD before
  // DONE ever reads it, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOAD) w_mem[wr_cnt_q] <= bus.text_i;
  end

  assign rd_idx     = RD_LAST - rd_cnt_q;
  assign bus.text_o = rd_active_q ? digest_q[rd_idx] : '0;
  assign bus.cmd_o  = cmd_q;

`ifdef SHA_CMD_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                                     err_q <= 1'b0;
    else if (bus.cmd_w_i && bus.cmd_i[1] && busy)     err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sha_ctrl_core.sv
// Self-checking bench for sha_ctrl_core: randomized blocks against a digest model,
// plus a small-parameter instance for modular wrap and word-index folding.
module tb_sha_ctrl_core;

  localparam int DW    = 32;
  localparam int BW    = 16;
  localparam int NDW   = 8;
  localparam int NR    = 64;
  localparam int B_DW  = 8;
  localparam int B_BW  = 4;
  localparam int B_NDW = 6;
  localparam int B_NR  = 3;
`ifdef SHA_CMD_ERR_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  sha_ctrl_if #(.DW(DW))   bus_a ();
  sha_ctrl_if #(.DW(B_DW)) bus_b ();

  sha_ctrl_core #(.DW(DW), .BLOCK_WORDS(BW), .DIGEST_WORDS(NDW), .ROUNDS(NR)) dut_a (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_a.slave)
  );

  sha_ctrl_core #(.DW(B_DW), .BLOCK_WORDS(B_BW), .DIGEST_WORDS(B_NDW), .ROUNDS(B_NR)) dut_b (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   dig_m [NDW];
  logic [DW-1:0]   msg   [BW];
  logic [B_DW-1:0] dig_b [B_NDW];

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Reference: one finished block adds message word i mod BW onto a zero or chained base.
  task automatic model_block(input bit internal);
    for (int i = 0; i < NDW; i++) dig_m[i] = (internal ? dig_m[i] : '0) + msg[i % BW];
  endtask

  // Starts (optionally) and runs one block on dut_a; measures start-to-idle latency.
  task automatic run_block(input string name, input bit start, input bit internal,
                           input bit with_read, input int err_at);
    logic [DW-1:0] old [NDW];
    int n;
    bit seen_high;
    old = dig_m;
    if (start) begin
      bus_a.cmd_i   = {internal, 1'b1, with_read};
      bus_a.cmd_w_i = 1'b1;
      tick;
      bus_a.cmd_w_i = 1'b0;
      tick;
    end
    n = 0;
    seen_high = 1'b0;
    while (!(seen_high && bus_a.cmd_o[3] == 1'b0) && n < 1000) begin
      if (with_read && n < NDW) begin
        checks++;
        if (bus_a.text_o !== old[n]) begin
          errors++;
          $display("FAIL %s read_during_load[%0d]: text_o=%h expected %h", name, n, bus_a.text_o, old[n]);
        end
      end
      if (n < BW) bus_a.text_i = msg[n];
      else        bus_a.text_i = DW'($urandom());
      if (n == err_at) begin
        bus_a.cmd_i   = 3'b010;
        bus_a.cmd_w_i = 1'b1;
      end
      tick;
      n++;
      bus_a.cmd_w_i = 1'b0;
      if (n - 1 == err_at) begin
        checks++;
        if (bus_a.err_o !== ERR_EXP) begin
          errors++;
          $display("FAIL %s err_set: err_o=%b expected %b", name, bus_a.err_o, ERR_EXP);
        end
      end
      if (bus_a.cmd_o[3]) seen_high = 1'b1;
    end
    checks++;
    if (n != 1 + BW + NR + 1) begin
      errors++;
      $display("FAIL %s latency: busy dropped after %0d cycles expected %0d", name, n, 1 + BW + NR + 1);
    end
    model_block(internal);
  endtask

  task automatic read_check(input string name);
    bus_a.cmd_i   = 3'b001;
    bus_a.cmd_w_i = 1'b1;
    tick;
    bus_a.cmd_w_i = 1'b0;
    checks++;
    if (bus_a.text_o !== '0) begin
      errors++;
      $display("FAIL %s pre_read: text_o=%h expected 0", name, bus_a.text_o);
    end
    tick;
    for (int k = 0; k < NDW; k++) begin
      checks++;
      if (bus_a.text_o !== dig_m[k]) begin
        errors++;
        $display("FAIL %s word[%0d]: text_o=%h expected %h", name, k, bus_a.text_o, dig_m[k]);
      end
      tick;
    end
    checks++;
    if (bus_a.text_o !== '0) begin
      errors++;
      $display("FAIL %s post_read: text_o=%h expected 0", name, bus_a.text_o);
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    repeat (3) tick;
    checks++;
    if (bus_a.cmd_o !== 4'h0 || bus_a.text_o !== '0 || bus_a.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: cmd_o=%h text_o=%h err_o=%b expected 0/0/0", bus_a.cmd_o, bus_a.text_o, bus_a.err_o);
    end
    checks++;
    if (bus_b.cmd_o !== 4'h0 || bus_b.text_o !== '0 || bus_b.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: cmd_o=%h text_o=%h err_o=%b expected 0/0/0", bus_b.cmd_o, bus_b.text_o, bus_b.err_o);
    end
    rst_n_i = 1'b1;
    tick;
    for (int i = 0; i < NDW; i++)   dig_m[i] = '0;
    for (int i = 0; i < B_NDW; i++) dig_b[i] = '0;
  endtask

  task automatic test_first_block;
    for (int i = 0; i < BW; i++) msg[i] = DW'(i + 1);
    run_block("first_block", 1'b1, 1'b0, 1'b0, -1);
    read_check("first_block");
  endtask

  task automatic test_internal_round;
    for (int i = 0; i < BW; i++) msg[i] = DW'('h10);
    run_block("internal_round", 1'b1, 1'b1, 1'b0, -1);
    read_check("internal_round");
  endtask

  task automatic test_random_blocks;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < BW; i++) msg[i] = DW'($urandom());
      run_block("random_block", 1'b1, 1'($urandom_range(0, 1)), 1'b0, -1);
      read_check("random_block");
    end
  endtask

  task automatic test_read_while_busy;
    int n;
    bit seen_high;
    bit zero_bad;
    for (int i = 0; i < BW; i++) msg[i] = DW'($urandom());
    bus_a.cmd_i   = 3'b010;
    bus_a.cmd_w_i = 1'b1;
    tick;
    bus_a.cmd_w_i = 1'b0;
    tick;
    n = 0;
    seen_high = 1'b0;
    zero_bad = 1'b0;
    while (!(seen_high && bus_a.cmd_o[3] == 1'b0) && n < 1000) begin
      if (n < BW) bus_a.text_i = msg[n];
      if (n == BW + 10) begin
        bus_a.cmd_i   = 3'b001;
        bus_a.cmd_w_i = 1'b1;
      end
      tick;
      n++;
      bus_a.cmd_w_i = 1'b0;
      if (bus_a.cmd_o[3]) begin
        seen_high = 1'b1;
        if (bus_a.text_o !== '0) zero_bad = 1'b1;
      end
    end
    model_block(1'b0);
    checks++;
    if (zero_bad || n >= 1000) begin
      errors++;
      $display("FAIL read_while_busy quiet: text_o nonzero while busy or no idle (cycles=%0d) expected zero", n);
    end
    for (int k = 0; k < NDW; k++) begin
      checks++;
      if (bus_a.text_o !== dig_m[k]) begin
        errors++;
        $display("FAIL read_while_busy word[%0d]: text_o=%h expected %h", k, bus_a.text_o, dig_m[k]);
      end
      tick;
    end
    checks++;
    if (bus_a.text_o !== '0) begin
      errors++;
      $display("FAIL read_while_busy post_read: text_o=%h expected 0", bus_a.text_o);
    end
  endtask

  task automatic test_read_restart;
    bus_a.cmd_i   = 3'b001;
    bus_a.cmd_w_i = 1'b1;
    tick;
    bus_a.cmd_w_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (k == 1) bus_a.cmd_w_i = 1'b1;
      checks++;
      if (bus_a.text_o !== dig_m[k]) begin
        errors++;
        $display("FAIL read_restart lead[%0d]: text_o=%h expected %h", k, bus_a.text_o, dig_m[k]);
      end
    end
    bus_a.cmd_w_i = 1'b0;
    for (int k = 0; k < NDW; k++) begin
      tick;
      checks++;
      if (bus_a.text_o !== dig_m[k]) begin
        errors++;
        $display("FAIL read_restart word[%0d]: text_o=%h expected %h", k, bus_a.text_o, dig_m[k]);
      end
    end
    tick;
  endtask

  task automatic test_load_and_read;
    for (int i = 0; i < BW; i++) msg[i] = DW'($urandom());
    run_block("load_and_read", 1'b1, 1'($urandom_range(0, 1)), 1'b1, -1);
    read_check("load_and_read");
  endtask

  task automatic test_err;
    for (int i = 0; i < BW; i++) msg[i] = DW'($urandom());
    run_block("err", 1'b1, 1'b0, 1'b0, 3);
    // The errant Round bit stays pending and launches one more block once idle.
    for (int i = 0; i < BW; i++) msg[i] = DW'($urandom());
    run_block("err_chain", 1'b0, 1'b0, 1'b0, -1);
    checks++;
    if (bus_a.err_o !== ERR_EXP) begin
      errors++;
      $display("FAIL err_sticky: err_o=%b expected %b", bus_a.err_o, ERR_EXP);
    end
    read_check("err_chain");
  endtask

  task automatic block_b(input string name, input bit internal, input logic [B_DW-1:0] w0);
    logic [B_DW-1:0] mb [B_BW];
    int n;
    bit seen_high;
    mb[0] = w0;
    for (int i = 1; i < B_BW; i++) mb[i] = B_DW'($urandom());
    bus_b.cmd_i   = {internal, 2'b10};
    bus_b.cmd_w_i = 1'b1;
    tick;
    bus_b.cmd_w_i = 1'b0;
    tick;
    n = 0;
    seen_high = 1'b0;
    while (!(seen_high && bus_b.cmd_o[3] == 1'b0) && n < 1000) begin
      if (n < B_BW) bus_b.text_i = mb[n];
      tick;
      n++;
      if (bus_b.cmd_o[3]) seen_high = 1'b1;
    end
    checks++;
    if (n != 1 + B_BW + B_NR + 1) begin
      errors++;
      $display("FAIL %s latency: busy dropped after %0d cycles expected %0d", name, n, 1 + B_BW + B_NR + 1);
    end
    for (int i = 0; i < B_NDW; i++) dig_b[i] = (internal ? dig_b[i] : '0) + mb[i % B_BW];
  endtask

  task automatic read_b(input string name);
    bus_b.cmd_i   = 3'b001;
    bus_b.cmd_w_i = 1'b1;
    tick;
    bus_b.cmd_w_i = 1'b0;
    tick;
    for (int k = 0; k < B_NDW; k++) begin
      checks++;
      if (bus_b.text_o !== dig_b[k]) begin
        errors++;
        $display("FAIL %s word[%0d]: text_o=%h expected %h", name, k, bus_b.text_o, dig_b[k]);
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    block_b("wrap_seed", 1'b0, 8'hF0);
    read_b("wrap_seed");
    block_b("wrap", 1'b1, 8'h20);
    read_b("wrap");
  endtask

  task automatic test_reset_mid_round;
    for (int i = 0; i < BW; i++) msg[i] = DW'($urandom());
    bus_a.cmd_i   = 3'b010;
    bus_a.cmd_w_i = 1'b1;
    tick;
    bus_a.cmd_w_i = 1'b0;
    tick;
    for (int n = 0; n < BW + 20; n++) begin
      if (n < BW) bus_a.text_i = msg[n];
      tick;
    end
    rst_n_i = 1'b0;
    tick;
    rst_n_i = 1'b1;
    checks++;
    if (bus_a.cmd_o !== 4'h0 || bus_a.text_o !== '0 || bus_a.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_round: cmd_o=%h text_o=%h err_o=%b expected 0/0/0", bus_a.cmd_o, bus_a.text_o, bus_a.err_o);
    end
    tick;
    checks++;
    if (bus_a.cmd_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_round busy: cmd_o[3]=%b expected 0", bus_a.cmd_o[3]);
    end
    for (int i = 0; i < NDW; i++) dig_m[i] = '0;
    read_check("reset_mid_round");
  endtask

  initial begin
    rst_n_i       = 1'b0;
    bus_a.text_i  = '0;
    bus_a.cmd_i   = '0;
    bus_a.cmd_w_i = 1'b0;
    bus_b.text_i  = '0;
    bus_b.cmd_i   = '0;
    bus_b.cmd_w_i = 1'b0;
    test_reset;
    test_first_block;
    test_internal_round;
    test_random_blocks;
    test_read_while_busy;
    test_read_restart;
    test_load_and_read;
    test_err;
    test_wrap;
    test_reset_mid_round;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
